// File: rtl/bullet_pool_pkg.sv
// Shared geometry, colour and box type for the bullet pool and its slots.
package bullet_pool_pkg;

  localparam int HRES          = 640;
  localparam int VRES          = 480;
  localparam int PADDLE_W      = 64;
  localparam int PADDLE_H      = 16;
  localparam int BULLET_W      = 4;
  localparam int BULLET_H      = 8;
  localparam int N_BULLETS_DEF = 4;

  localparam logic [2:0][7:0] BULLET_COLOR = {8'hFF, 8'hFF, 8'h40};

  localparam logic signed [11:0] BULLET_W_S = 12'(BULLET_W);
  localparam logic signed [11:0] BULLET_H_S = 12'(BULLET_H);
  localparam logic signed [11:0] SPAWN_TOP  = 12'(VRES - PADDLE_H - BULLET_H);
  localparam logic signed [12:0] SPAWN_OFS  = 13'(PADDLE_W / 2 - BULLET_W / 2);
  localparam logic signed [12:0] LEFT_MAX   = 13'(HRES - BULLET_W);

  typedef struct packed {
    logic              active;
    logic signed [11:0] left;
    logic signed [11:0] top;
  } bullet_box_t;

  // Centre the bullet on the paddle; 13-bit sum so an extreme player_x cannot wrap.
  function automatic logic signed [11:0] spawn_left(input logic signed [11:0] px);
    logic signed [12:0] x;
    x = $signed({px[11], px}) + SPAWN_OFS;
    if (x < 13'sd0) begin
      spawn_left = 12'sd0;
    end else if (x > LEFT_MAX) begin
      spawn_left = LEFT_MAX[11:0];
    end else begin
      spawn_left = x[11:0];
    end
  endfunction

endpackage

// File: rtl/bullet_pool_slot.sv
// One bullet slot: holds its box, climbs on fsync, retires off-screen or on kill,
// loads a new box on spawn and reports whether the scan position hits it.
module bullet_pool_slot
  import bullet_pool_pkg::*;
#(
  parameter int BULLET_SPEED = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_fsync,
  input  logic               i_kill,
  input  logic               i_spawn,
  input  logic signed [11:0] i_spawn_left,
  input  logic signed [11:0] i_hpos,
  input  logic signed [11:0] i_vpos,
  output bullet_box_t        o_box,
  output logic signed [11:0] o_right,
  output logic signed [11:0] o_bottom,
  output logic               o_active_nxt,
  output logic               o_hit
);

  localparam logic signed [11:0] SPEED = 12'(BULLET_SPEED);

  bullet_box_t        r_box;
  bullet_box_t        w_box_nxt;
  logic signed [11:0] r_right;
  logic signed [11:0] r_bottom;
  logic signed [11:0] w_top_moved;

  assign w_top_moved = r_box.top - SPEED;

  // Kill beats motion, so a slot killed on an fsync is neither moved nor reusable that cycle.
  always_comb begin
    w_box_nxt = r_box;
    if (i_kill && r_box.active) begin
      w_box_nxt = '0;
    end else if (i_fsync && r_box.active) begin
      if (w_top_moved + BULLET_H_S <= 12'sd0) begin
        w_box_nxt = '0;
      end else begin
        w_box_nxt.top = w_top_moved;
      end
    end else if (i_spawn && !r_box.active) begin
      w_box_nxt = '{active: 1'b1, left: i_spawn_left, top: SPAWN_TOP};
    end else begin
      w_box_nxt = r_box;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_box    <= '0;
      r_right  <= 12'sd0;
      r_bottom <= 12'sd0;
    end else begin
      r_box    <= w_box_nxt;
      r_right  <= w_box_nxt.active ? (w_box_nxt.left + BULLET_W_S) : 12'sd0;
      r_bottom <= w_box_nxt.active ? (w_box_nxt.top + BULLET_H_S) : 12'sd0;
    end
  end

  assign o_box        = r_box;
  assign o_right      = r_right;
  assign o_bottom     = r_bottom;
  assign o_active_nxt = w_box_nxt.active;
  assign o_hit        = r_box.active && (i_hpos >= r_box.left) && (i_hpos < r_right) &&
                        (i_vpos >= r_box.top) && (i_vpos < r_bottom);

endmodule

// File: rtl/bullet_pool.sv
// Multi-shot projectile pool: fire arming, cooldown, lowest-free-slot spawn, pixel OR, live count.
// Optional BULLET_POOL_AUTOFIRE_EN: a held fire button re-arms at every fsync with cooldown expired.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int N_BULLETS       = N_BULLETS_DEF,
  parameter int BULLET_SPEED    = 8,
  parameter int COOLDOWN_FRAMES = 6,
  localparam int CW             = $clog2(N_BULLETS + 1)
) (
  input  logic                       i_pixel_clk,
  input  logic                       i_rst_n,
  input  logic                       i_fsync,
  input  logic                       i_fire,
  input  logic [N_BULLETS-1:0]       i_kill,
  input  logic signed [11:0]         i_player_x,
  input  logic signed [11:0]         i_hpos,
  input  logic signed [11:0]         i_vpos,
  output logic [2:0][7:0]            o_pixel,
  output logic [N_BULLETS-1:0]       o_bullet_active,
  output logic [N_BULLETS-1:0][11:0] o_bullet_left,
  output logic [N_BULLETS-1:0][11:0] o_bullet_right,
  output logic [N_BULLETS-1:0][11:0] o_bullet_top,
  output logic [N_BULLETS-1:0][11:0] o_bullet_bottom,
  output logic [CW-1:0]              o_active_count,
  output logic                       o_fire_dropped
);

  localparam int CDW = $clog2(COOLDOWN_FRAMES + 2);

  logic                 r_fire_prev;
  logic                 r_pending;
  logic [CDW-1:0]       r_cooldown;
  logic                 r_dropped;
  logic [CW-1:0]        r_count;
  logic [2:0][7:0]      r_pixel;
  logic                 w_fire_edge;
  logic                 w_req;
  logic                 w_go;
  logic [N_BULLETS-1:0] w_free;
  logic [N_BULLETS-1:0] w_spawn_vec;
  logic [N_BULLETS-1:0] w_active_nxt;
  logic [N_BULLETS-1:0] w_hit;
  logic [CW-1:0]        w_count;
  logic signed [11:0]   w_spawn_left;

  assign w_fire_edge = i_fire & ~r_fire_prev;
`ifdef BULLET_POOL_AUTOFIRE_EN
  assign w_req = r_pending | w_fire_edge | i_fire;
`else
  assign w_req = r_pending | w_fire_edge;
`endif
  assign w_go         = i_fsync & w_req & (r_cooldown == '0);
  assign w_free       = ~o_bullet_active;
  assign w_spawn_vec  = w_go ? (w_free & (~w_free + N_BULLETS'(1'b1))) : '0;
  assign w_spawn_left = spawn_left(i_player_x);

  for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
    bullet_box_t w_box;
    bullet_pool_slot #(.BULLET_SPEED(BULLET_SPEED)) u_slot (
      .i_clk        (i_pixel_clk),
      .i_rst_n      (i_rst_n),
      .i_fsync      (i_fsync),
      .i_kill       (i_kill[g]),
      .i_spawn      (w_spawn_vec[g]),
      .i_spawn_left (w_spawn_left),
      .i_hpos       (i_hpos),
      .i_vpos       (i_vpos),
      .o_box        (w_box),
      .o_right      (o_bullet_right[g]),
      .o_bottom     (o_bullet_bottom[g]),
      .o_active_nxt (w_active_nxt[g]),
      .o_hit        (w_hit[g])
    );
    assign o_bullet_active[g] = w_box.active;
    assign o_bullet_left[g]   = w_box.left;
    assign o_bullet_top[g]    = w_box.top;
  end

  // Count the post-edge live set so the count lines up with the slot flags.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      w_count = w_count + CW'(w_active_nxt[i]);
    end
  end

  // A held button at reset release must not look like a fresh press, hence prev resets high.
  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fire_prev <= 1'b1;
      r_pending   <= 1'b0;
      r_cooldown  <= '0;
      r_dropped   <= 1'b0;
      r_count     <= '0;
      r_pixel     <= '0;
    end else begin
      r_fire_prev <= i_fire;
      r_dropped   <= w_go & ~(|w_free);
      r_count     <= w_count;
      r_pixel     <= (|w_hit) ? BULLET_COLOR : '0;
      if (i_fsync) begin
        r_pending <= 1'b0;
        if (w_go && (|w_free)) begin
          r_cooldown <= CDW'(COOLDOWN_FRAMES);
        end else if (r_cooldown != '0) begin
          r_cooldown <= r_cooldown - CDW'(1);
        end else begin
          r_cooldown <= r_cooldown;
        end
      end else begin
        r_pending  <= r_pending | w_fire_edge;
        r_cooldown <= r_cooldown;
      end
    end
  end

  assign o_pixel        = r_pixel;
  assign o_active_count = r_count;
  assign o_fire_dropped = r_dropped;

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: directed scenarios plus a random phase, all
// compared every cycle against a slot-list reference model.
module tb_bullet_pool;
  import bullet_pool_pkg::*;

  localparam int N     = 4;
  localparam int SPEED = 8;
  localparam int COOL  = 6;
  localparam int CW    = 3;
`ifdef BULLET_POOL_AUTOFIRE_EN
  localparam int HOLD_SPAWNS = 3;
  localparam int RST_SPAWNS  = 1;
`else
  localparam int HOLD_SPAWNS = 1;
  localparam int RST_SPAWNS  = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               fsync = 1'b0;
  logic               fire = 1'b0;
  logic [N-1:0]       kill = '0;
  logic signed [11:0] player_x = '0;
  logic signed [11:0] hpos = '0;
  logic signed [11:0] vpos = '0;
  logic [2:0][7:0]    pixel;
  logic [N-1:0]       b_active;
  logic [N-1:0][11:0] b_left, b_right, b_top, b_bottom;
  logic [CW-1:0]      count;
  logic               dropped;

  int n_checks = 0;
  int n_errors = 0;

  bit m_act[N];
  int m_left[N];
  int m_top[N];
  bit m_pending, m_prev, m_drop, m_hit;
  int m_cd;

  always #5 clk = ~clk;

  bullet_pool #(.N_BULLETS(N), .BULLET_SPEED(SPEED), .COOLDOWN_FRAMES(COOL)) dut (
    .i_pixel_clk(clk), .i_rst_n(rst_n), .i_fsync(fsync), .i_fire(fire), .i_kill(kill),
    .i_player_x(player_x), .i_hpos(hpos), .i_vpos(vpos), .o_pixel(pixel),
    .o_bullet_active(b_active), .o_bullet_left(b_left), .o_bullet_right(b_right),
    .o_bullet_top(b_top), .o_bullet_bottom(b_bottom), .o_active_count(count),
    .o_fire_dropped(dropped)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model();
    bit edge_f, req, free_v[N];
    int s, x;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_act[i] = 0; m_left[i] = 0; m_top[i] = 0; end
      m_pending = 0; m_prev = 1; m_drop = 0; m_hit = 0; m_cd = 0;
      return;
    end
    edge_f = fire && !m_prev;
    req = m_pending || edge_f;
`ifdef BULLET_POOL_AUTOFIRE_EN
    req = req || fire;
`endif
    m_hit = 0;
    for (int i = 0; i < N; i++) begin
      free_v[i] = !m_act[i];
      if (m_act[i] && hpos >= m_left[i] && hpos < m_left[i] + BULLET_W &&
          vpos >= m_top[i] && vpos < m_top[i] + BULLET_H) m_hit = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (kill[i] && m_act[i]) begin
        m_act[i] = 0; m_left[i] = 0; m_top[i] = 0;
      end else if (fsync && m_act[i]) begin
        m_top[i] -= SPEED;
        if (m_top[i] + BULLET_H <= 0) begin m_act[i] = 0; m_left[i] = 0; m_top[i] = 0; end
      end
    end
    m_drop = 0;
    if (fsync) begin
      if (req && m_cd == 0) begin
        s = -1;
        for (int i = N - 1; i >= 0; i--) if (free_v[i]) s = i;
        if (s >= 0) begin
          x = int'(player_x) + PADDLE_W / 2 - BULLET_W / 2;
          if (x < 0) x = 0;
          if (x > HRES - BULLET_W) x = HRES - BULLET_W;
          m_act[s] = 1; m_left[s] = x; m_top[s] = VRES - PADDLE_H - BULLET_H;
          m_cd = COOL;
        end else begin
          m_drop = 1;
        end
      end else if (m_cd > 0) begin
        m_cd--;
      end
      m_pending = 0;
    end else begin
      m_pending = m_pending || edge_f;
    end
    m_prev = fire;
  endtask

  task automatic compare();
    logic [N-1:0] e_act;
    logic [N-1:0][11:0] e_l, e_r, e_t, e_b;
    int c;
    c = 0;
    for (int i = 0; i < N; i++) begin
      e_act[i] = m_act[i];
      e_l[i] = 12'(m_left[i]);
      e_t[i] = 12'(m_top[i]);
      e_r[i] = m_act[i] ? 12'(m_left[i] + BULLET_W) : 12'd0;
      e_b[i] = m_act[i] ? 12'(m_top[i] + BULLET_H) : 12'd0;
      c += int'(m_act[i]);
    end
    chk("active", 64'(b_active), 64'(e_act));
    chk("left", 64'(b_left), 64'(e_l));
    chk("right", 64'(b_right), 64'(e_r));
    chk("top", 64'(b_top), 64'(e_t));
    chk("bottom", 64'(b_bottom), 64'(e_b));
    chk("count", 64'(count), 64'(c));
    chk("dropped", 64'(dropped), 64'(m_drop));
    chk("pixel", 64'(pixel), m_hit ? 64'(BULLET_COLOR) : 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    compare();
  endtask

  initial begin
    int j;
    // Reset and idle frames
    rst_n = 1'b0;
    repeat (5) step();
    chk("rst_active", 64'(b_active), 64'd0);
    chk("rst_pixel", 64'(pixel), 64'd0);
    rst_n = 1'b1;
    repeat (3) begin fsync = 1'b1; step(); fsync = 1'b0; step(); end
    chk("idle_count", 64'(count), 64'd0);

    // Single shot with right-edge clamp, then climb to retirement
    player_x = 12'(HRES - 20);
    fire = 1'b1; step(); fire = 1'b0; step();
    fsync = 1'b1; step(); fsync = 1'b0;
    chk("spawn_left", 64'(b_left[0]), 64'd636);
    chk("spawn_top", 64'(b_top[0]), 64'd456);
    for (int k = 1; k <= 58; k++) begin
      fsync = 1'b1; step(); fsync = 1'b0; step();
      if (k == 1) chk("top_after1", 64'(b_top[0]), 64'd448);
      if (k == 57) chk("alive57", 64'(b_active[0]), 64'd1);
    end
    chk("retired58", 64'(b_active[0]), 64'd0);

    // Cooldown spacing and full pool
    player_x = 12'sd100;
    for (int f = 1; f <= 29; f++) begin
      fire = 1'b1; fsync = 1'b1; step(); fire = 1'b0; fsync = 1'b0;
      if (f == 1)  chk("spawn_f1", 64'(b_active), 64'h1);
      if (f == 7)  chk("cool_f7", 64'(b_active), 64'h1);
      if (f == 8)  chk("spawn_f8", 64'(b_active), 64'h3);
      if (f == 22) chk("full_f22", 64'(b_active), 64'hF);
      if (f == 29) begin
        chk("drop_pulse", 64'(dropped), 64'd1);
        chk("count_full", 64'(count), 64'd4);
      end
      step();
      if (f == 29) chk("drop_end", 64'(dropped), 64'd0);
    end

    // Kill with fsync, then reuse of the freed slot
    kill = 4'b1000; step(); kill = '0;
    kill = 4'b0010; fsync = 1'b1; step(); kill = '0; fsync = 1'b0;
    chk("kill_mask", 64'(b_active), 64'h5);
    step();
    fire = 1'b1; fsync = 1'b1; step(); fire = 1'b0; fsync = 1'b0;
    chk("reuse_slot1", 64'(b_active), 64'h7);
    step();

    // Pixel probe on slot 2
    hpos = 12'(m_left[2] + 1); vpos = 12'(m_top[2] + 1); step();
    chk("pix_inside", 64'(pixel), 64'(BULLET_COLOR));
    hpos = 12'(m_left[2] + BULLET_W); step();
    chk("pix_right_edge", 64'(pixel), 64'd0);

    // Held fire for 20 frames from an empty pool
    kill = 4'hF; step(); kill = '0;
    repeat (8) begin fsync = 1'b1; step(); fsync = 1'b0; step(); end
    fire = 1'b1;
    repeat (20) begin fsync = 1'b1; step(); fsync = 1'b0; step(); end
    fire = 1'b0; step();
    chk("hold_spawns", 64'(count), 64'(HOLD_SPAWNS));

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      fsync = ($urandom_range(0, 3) == 0);
      fire = 1'($urandom_range(0, 1));
      kill = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) player_x = 12'($urandom_range(0, 4095));
      j = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 1) == 1) begin
        hpos = 12'(m_left[j] + int'($urandom_range(0, 6)) - 1);
        vpos = 12'(m_top[j] + int'($urandom_range(0, 10)) - 1);
      end else begin
        hpos = 12'($urandom_range(0, 700));
        vpos = 12'($urandom_range(0, 500));
      end
      step();
    end
    fsync = 1'b0; kill = '0;

    // Reset asserted mid-frame with fire held through release
    fire = 1'b1;
    rst_n = 1'b0; step(); step();
    rst_n = 1'b1;
    repeat (3) begin fsync = 1'b1; step(); fsync = 1'b0; step(); end
    chk("post_rst_count", 64'(count), 64'(RST_SPAWNS));
    fire = 1'b0; step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
